robo_sequenciador: RTL and testbench

Cycle-level sequencer that sits between the raw sensor/motor pins and the navigation core FSM. It freezes a sensor snapshot, grants the core one decision step, captures the core's command and next heading, and then drives exactly one motor for a timed interval. It also owns the heading register, debris and advance counters, stuck-rotation detection, and the core's hold/restart.

---
 rtl/robo_sequenciador_if.sv | 26 ++
 rtl/robo_sequenciador.sv | 159 +++++++++++++++
 tb/tb_robo_sequenciador.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/robo_sequenciador_if.sv
// Sequencer <-> navigation core link: frozen snapshot, step/hold control, heading and the core's commands.
interface robo_sequenciador_if;
  logic       core_head;
  logic       core_left;
  logic       core_under;
  logic       core_barrier;
  logic       core_step;
  logic       core_rst;
  logic [1:0] direcao;
  logic       core_avancar;
  logic       core_girar;
  logic       core_recolher;
  logic [1:0] core_direcao_next;

  modport master (
    output core_head, core_left, core_under, core_barrier,
    output core_step, core_rst, direcao,
    input  core_avancar, core_girar, core_recolher, core_direcao_next
  );

  modport slave (
    input  core_head, core_left, core_under, core_barrier,
    input  core_step, core_rst, direcao,
    output core_avancar, core_girar, core_recolher, core_direcao_next
  );
endinterface

// File: rtl/robo_sequenciador.sv
// Sensor-snapshot / single-step / timed-motor sequencer wrapped around the navigation core FSM.
// Owns heading, advance and debris counters, stuck-turn detection and the core's hold.
module robo_sequenciador #(
  parameter int unsigned STEP_DIV       = 4,
  parameter int unsigned COLLECT_CYCLES = 3,
  parameter int unsigned TURN_LIMIT     = 4,
  parameter int unsigned CNT_W          = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 head,
  input  logic                 left,
  input  logic                 under,
  input  logic                 barrier,
  robo_sequenciador_if.master  core,
  output logic                 mot_avancar,
  output logic                 mot_girar,
  output logic                 mot_recolher,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_W-1:0]     passos,
  output logic [CNT_W-1:0]     entulhos
);

  localparam int unsigned MAX_IVL = (STEP_DIV > COLLECT_CYCLES) ? STEP_DIV : COLLECT_CYCLES;
  localparam int unsigned IW      = $clog2(MAX_IVL + 1);
  localparam int unsigned TW      = $clog2(TURN_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SAMPLE, S_STEP, S_MOVE, S_TURN, S_COLLECT, S_HALT, S_FAULT
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       snap_q, snap_d;
  logic [1:0]       dir_q, dir_d;
  logic [TW-1:0]    turn_q, turn_d;
  logic [IW-1:0]    ivl_q, ivl_d;
  logic [CNT_W-1:0] passos_d, entulhos_d;
  logic             step_q, crst_q;

  assign core.core_head    = snap_q[3];
  assign core.core_left    = snap_q[2];
  assign core.core_under   = snap_q[1];
  assign core.core_barrier = snap_q[0];
  assign core.direcao      = dir_q;
  assign core.core_step    = step_q;
  assign core.core_rst     = crst_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state plus datapath updates; command priority is recolher > girar > avancar.
  always_comb begin
    state_d    = state_q;
    snap_d     = snap_q;
    dir_d      = dir_q;
    turn_d     = turn_q;
    ivl_d      = ivl_q;
    passos_d   = passos;
    entulhos_d = entulhos;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) state_d = S_SAMPLE;
      end
      S_FAULT: begin
        if (start) begin
          state_d = S_SAMPLE;
          turn_d  = '0;
        end
      end
      S_SAMPLE: begin
        snap_d  = {head, left, under, barrier};
        state_d = S_STEP;
      end
      S_STEP: begin
        if (core.core_recolher) begin
          state_d = S_COLLECT;
          ivl_d   = IW'(COLLECT_CYCLES - 1);
        end else if (core.core_girar) begin
          state_d = S_TURN;
          dir_d   = core.core_direcao_next;
          turn_d  = turn_q + TW'(1);
          ivl_d   = IW'(STEP_DIV - 1);
        end else if (core.core_avancar) begin
          state_d = S_MOVE;
          turn_d  = '0;
          ivl_d   = IW'(STEP_DIV - 1);
        end else begin
          state_d = S_HALT;
        end
      end
      S_MOVE: begin
        if (ivl_q == '0) begin
          state_d = S_SAMPLE;
          if (passos != '1) passos_d = passos + CNT_W'(1);
        end else begin
          ivl_d = ivl_q - IW'(1);
        end
      end
      S_TURN: begin
        if (ivl_q == '0) begin
          state_d = (turn_q == TW'(TURN_LIMIT)) ? S_FAULT : S_SAMPLE;
        end else begin
          ivl_d = ivl_q - IW'(1);
        end
      end
      S_COLLECT: begin
        if (ivl_q == '0) begin
          state_d = S_SAMPLE;
          if (entulhos != '1) entulhos_d = entulhos + CNT_W'(1);
        end else begin
          ivl_d = ivl_q - IW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      snap_q       <= '0;
      dir_q        <= '0;
      turn_q       <= '0;
      ivl_q        <= '0;
      passos       <= '0;
      entulhos     <= '0;
      step_q       <= 1'b0;
      crst_q       <= 1'b1;
      mot_avancar  <= 1'b0;
      mot_girar    <= 1'b0;
      mot_recolher <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      fault        <= 1'b0;
    end else begin
      snap_q       <= snap_d;
      dir_q        <= dir_d;
      turn_q       <= turn_d;
      ivl_q        <= ivl_d;
      passos       <= passos_d;
      entulhos     <= entulhos_d;
      step_q       <= (state_d == S_STEP);
      crst_q       <= (state_d == S_IDLE) || (state_d == S_HALT) || (state_d == S_FAULT);
      mot_avancar  <= (state_d == S_MOVE);
      mot_girar    <= (state_d == S_TURN);
      mot_recolher <= (state_d == S_COLLECT);
      busy         <= (state_d == S_SAMPLE) || (state_d == S_STEP) || (state_d == S_MOVE) ||
                      (state_d == S_TURN)   || (state_d == S_COLLECT);
      halted       <= (state_d == S_HALT);
      fault        <= (state_d == S_FAULT);
    end
  end

endmodule

// File: tb/tb_robo_sequenciador.sv
// Scoreboard bench for robo_sequenciador: the bench plays the navigation core and checks every motor/halt/fault event.
module tb_robo_sequenciador;

  localparam logic [2:0] K_MOVE    = 3'd1;
  localparam logic [2:0] K_TURN    = 3'd2;
  localparam logic [2:0] K_COLLECT = 3'd3;
  localparam logic [2:0] K_HALT    = 3'd4;
  localparam logic [2:0] K_FAULT   = 3'd5;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] len;
    logic [7:0] p;
    logic [7:0] e;
    logic [1:0] d;
    logic [3:0] snap;
    logic       rst;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       head, left, under, barrier;
  logic       mot_avancar, mot_girar, mot_recolher;
  logic       busy, halted, fault;
  logic [7:0] passos, entulhos;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ev    = 0;
  ev_t exp_q[$];

  robo_sequenciador_if bus ();

  assign bus.core_direcao_next = bus.direcao + 2'd1;

  robo_sequenciador dut (
    .clock        (clk),
    .reset        (reset),
    .start        (start),
    .head         (head),
    .left         (left),
    .under        (under),
    .barrier      (barrier),
    .core         (bus),
    .mot_avancar  (mot_avancar),
    .mot_girar    (mot_girar),
    .mot_recolher (mot_recolher),
    .busy         (busy),
    .halted       (halted),
    .fault        (fault),
    .passos       (passos),
    .entulhos     (entulhos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic [2:0] kind, input logic [7:0] len, input logic [7:0] p,
                           input logic [7:0] e, input logic [1:0] d, input logic [3:0] snap,
                           input logic rst);
    ev_t ev;
    ev = '{kind: kind, len: len, p: p, e: e, d: d, snap: snap, rst: rst};
    exp_q.push_back(ev);
  endtask

  task automatic observe(input logic [2:0] kind, input logic [7:0] len);
    ev_t obs, req;
    obs = '{kind: kind, len: len, p: passos, e: entulhos, d: bus.direcao,
            snap: {bus.core_head, bus.core_left, bus.core_under, bus.core_barrier},
            rst: bus.core_rst};
    n_tests++;
    n_ev++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event_%0d: got kind=%0d len=%0d passos=%0d, expected no event",
               n_ev, obs.kind, obs.len, obs.p);
    end else begin
      req = exp_q.pop_front();
      if (obs !== req) begin
        n_fail++;
        $display("FAIL event_%0d: got kind=%0d len=%0d passos=%0d entulhos=%0d dir=%0d snap=%b rst=%b, expected kind=%0d len=%0d passos=%0d entulhos=%0d dir=%0d snap=%b rst=%b",
                 n_ev, obs.kind, obs.len, obs.p, obs.e, obs.d, obs.snap, obs.rst,
                 req.kind, req.len, req.p, req.e, req.d, req.snap, req.rst);
      end
    end
  endtask

  task automatic wait_drained(input int budget, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d pending events, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // Monitor: motor falls and halt/fault rises are the observable responses.
  initial begin
    logic [2:0] mot, prev_mot;
    logic [7:0] len;
    logic       prev_halt, prev_fault;
    prev_mot = '0; len = '0; prev_halt = 1'b0; prev_fault = 1'b0;
    forever begin
      @(negedge clk);
      mot = {mot_recolher, mot_girar, mot_avancar};
      chk("motor_onehot", 32'($countones(mot) <= 1), 32'd1);
      if (reset) begin
        prev_mot = '0; len = '0; prev_halt = 1'b0; prev_fault = 1'b0;
      end else begin
        if (mot != '0) len = len + 8'd1;
        if (prev_mot != '0 && mot == '0) begin
          observe(prev_mot[0] ? K_MOVE : (prev_mot[1] ? K_TURN : K_COLLECT), len);
          len = '0;
        end
        if (halted && !prev_halt)  observe(K_HALT, 8'd0);
        if (fault  && !prev_fault) observe(K_FAULT, 8'd0);
        prev_mot   = mot;
        prev_halt  = halted;
        prev_fault = fault;
      end
    end
  end

  initial begin
    int found;
    reset = 1'b1; start = 1'b0;
    head = 1'b0; left = 1'b0; under = 1'b0; barrier = 1'b0;
    bus.core_avancar = 1'b0; bus.core_girar = 1'b0; bus.core_recolher = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_core_rst", 32'(bus.core_rst), 32'd1);
    chk("rst_motors", 32'({mot_avancar, mot_girar, mot_recolher}), 32'd0);
    chk("rst_status", 32'({busy, halted, fault, bus.core_step}), 32'd0);
    chk("rst_direcao", 32'(bus.direcao), 32'd0);
    chk("rst_counters", 32'({passos, entulhos}), 32'd0);
    @(negedge clk) reset = 1'b0;

    // Single advance with exact start/step/motor timing, then HALT.
    @(negedge clk) begin start = 1'b1; bus.core_avancar = 1'b1; end
    @(posedge clk) #1;
    chk("sample_busy", 32'(busy), 32'd1);
    chk("sample_step", 32'(bus.core_step), 32'd0);
    chk("sample_core_rst", 32'(bus.core_rst), 32'd0);
    start = 1'b0;
    @(posedge clk) #1;
    chk("step_high", 32'(bus.core_step), 32'd1);
    chk("step_motor_low", 32'(mot_avancar), 32'd0);
    expect_ev(K_MOVE, 8'd4, 8'd1, 8'd0, 2'd0, 4'b0000, 1'b0);
    expect_ev(K_HALT, 8'd0, 8'd1, 8'd0, 2'd0, 4'b0001, 1'b1);
    @(posedge clk) #1;
    chk("step_one_cycle", 32'(bus.core_step), 32'd0);
    chk("move_motor_high", 32'(mot_avancar), 32'd1);
    bus.core_avancar = 1'b0;
    barrier = 1'b1;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    chk("barrier_frozen", 32'(bus.core_barrier), 32'd0);
    wait_drained(40, "advance");
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_core_rst", 32'(bus.core_rst), 32'd1);
    chk("halt_not_busy", 32'(busy), 32'd0);

    // Repeated turns until the stuck-rotation fault.
    barrier = 1'b0;
    bus.core_girar = 1'b1;
    expect_ev(K_TURN, 8'd4, 8'd1, 8'd0, 2'd1, 4'b0000, 1'b0);
    expect_ev(K_TURN, 8'd4, 8'd1, 8'd0, 2'd2, 4'b0000, 1'b0);
    expect_ev(K_TURN, 8'd4, 8'd1, 8'd0, 2'd3, 4'b0000, 1'b0);
    expect_ev(K_TURN, 8'd4, 8'd1, 8'd0, 2'd0, 4'b0000, 1'b1);
    expect_ev(K_FAULT, 8'd0, 8'd1, 8'd0, 2'd0, 4'b0000, 1'b1);
    pulse_start();
    wait_drained(80, "turns");
    chk("fault_motors", 32'({mot_avancar, mot_girar, mot_recolher}), 32'd0);

    // recolher wins over avancar; then four fresh turns fault again (count cleared on restart).
    bus.core_girar = 1'b0; bus.core_recolher = 1'b1; bus.core_avancar = 1'b1;
    expect_ev(K_COLLECT, 8'd3, 8'd1, 8'd1, 2'd0, 4'b0000, 1'b0);
    pulse_start();
    wait_drained(30, "collect");
    bus.core_recolher = 1'b0; bus.core_avancar = 1'b0; bus.core_girar = 1'b1;
    expect_ev(K_TURN, 8'd4, 8'd1, 8'd1, 2'd1, 4'b0000, 1'b0);
    expect_ev(K_TURN, 8'd4, 8'd1, 8'd1, 2'd2, 4'b0000, 1'b0);
    expect_ev(K_TURN, 8'd4, 8'd1, 8'd1, 2'd3, 4'b0000, 1'b0);
    expect_ev(K_TURN, 8'd4, 8'd1, 8'd1, 2'd0, 4'b0000, 1'b1);
    expect_ev(K_FAULT, 8'd0, 8'd1, 8'd1, 2'd0, 4'b0000, 1'b1);
    wait_drained(80, "turns2");

    // Advance until passos saturates, plus one extra advance.
    bus.core_girar = 1'b0; bus.core_avancar = 1'b1;
    head = 1'b1; under = 1'b1;
    for (int i = 0; i < 255; i++)
      expect_ev(K_MOVE, 8'd4, (i + 2 > 255) ? 8'd255 : 8'(i + 2), 8'd1, 2'd0, 4'b1010, 1'b0);
    pulse_start();
    wait_drained(1600, "saturate");
    bus.core_avancar = 1'b0;
    expect_ev(K_HALT, 8'd0, 8'd255, 8'd1, 2'd0, 4'b1010, 1'b1);
    wait_drained(20, "sat_halt");

    // One turn to move the heading off 00, then reset in cycle 2 of an advance.
    head = 1'b0; under = 1'b1; left = 1'b1;
    bus.core_girar = 1'b1;
    expect_ev(K_TURN, 8'd4, 8'd255, 8'd1, 2'd1, 4'b0110, 1'b0);
    pulse_start();
    wait_drained(30, "pre_reset_turn");
    bus.core_girar = 1'b0; bus.core_avancar = 1'b1;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      @(posedge clk) #1;
      if (mot_avancar) found = 1;
    end
    chk("move_before_reset", 32'(found), 32'd1);
    @(posedge clk) #2;
    reset = 1'b1;
    #1;
    chk("async_mot_avancar", 32'(mot_avancar), 32'd0);
    chk("async_direcao", 32'(bus.direcao), 32'd0);
    chk("async_core_rst", 32'(bus.core_rst), 32'd1);
    chk("async_counters", 32'({passos, entulhos}), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    bus.core_avancar = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(posedge clk) #1;
    chk("idle_after_reset", 32'({busy, halted, fault, bus.core_rst}), 32'b0001);
    chk("no_pending_events", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
